// File: rtl/pipe_stage_skid_reg.sv
// Two-slot skid register for a pipeline stage boundary.
//
//   state | meaning
//   ------+----------------------------------------------
//   EMPTY | nothing held; out_valid low, in_ready high
//   ONE   | main slot valid; out_valid high, in_ready high
//   FULL  | main and skid valid; out_valid high, in_ready low
//
// in_ready comes straight from a flop, so downstream out_ready never reaches
// upstream combinationally; the skid slot absorbs the one payload that can
// arrive in the cycle the stall becomes visible.
module pipe_stage_skid_reg #(
   parameter int WIDTH          = 32,
   parameter bit CLEAR_ON_FLUSH = 1'b1,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] main_q, main_nxt;
   logic [WIDTH-1:0] skid_q, skid_nxt;
   logic             in_ready_q;
   logic [CNT_W-1:0] stall_q;
   logic             accept;
   logic             pop;

   assign out_valid = (state != EMPTY);
   assign out_data  = main_q;
   assign in_ready  = in_ready_q;
   assign occupancy = state;
   assign stall_cnt = stall_q;
   assign accept    = in_valid & in_ready_q;
   assign pop       = out_valid & out_ready;

   // Next-state and slot contents; flush overrides any handshake in the same cycle.
   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      if (flush) begin
         state_nxt = EMPTY;
         if (CLEAR_ON_FLUSH) begin
            main_nxt = '0;
            skid_nxt = '0;
         end
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_nxt  = in_data;
                  state_nxt = ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  main_nxt = in_data;
               end else if (accept) begin
                  skid_nxt  = in_data;
                  state_nxt = FULL;
               end else if (pop) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  main_nxt  = skid_q;
                  state_nxt = ONE;
               end
            end
            default: begin
               state_nxt = EMPTY;
            end
         endcase
      end
   end

   // State, slots and the registered ready flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_nxt;
         main_q     <= main_nxt;
         skid_q     <= skid_nxt;
         in_ready_q <= (state_nxt != FULL);
      end
   end

   // Saturating count of cycles where downstream holds off a valid payload.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: queue-based reference model checked every
// cycle, plus directed sequences with literal expectations.
module tb_pipe_stage_skid_reg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] stall_cnt;

   int tests = 0;
   int fails = 0;
   bit check_en = 0;

   // reference model state
   logic [WIDTH-1:0] mq[$];
   logic [WIDTH-1:0] m_last;
   int               m_stall;
   int               seen_c;

   pipe_stage_skid_reg #(
      .WIDTH(WIDTH),
      .CLEAR_ON_FLUSH(1'b1),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_ready(out_ready),
      .occupancy(occupancy),
      .stall_cnt(stall_cnt)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // model: a FIFO of at most two payloads, updated from the inputs seen at each edge
   always @(posedge clk) begin
      bit ov, ir, pop, acc;
      if (!rst) begin
         mq.delete();
         m_last  = '0;
         m_stall = 0;
      end else begin
         ov = (mq.size() > 0);
         ir = (mq.size() < 2);
         if (ov && !out_ready && m_stall < CNT_MAX) m_stall++;
         if (flush) begin
            mq.delete();
            m_last = '0;
         end else begin
            pop = ov && out_ready;
            acc = in_valid && ir;
            if (pop) m_last = mq.pop_front();
            if (acc) mq.push_back(in_data);
         end
      end
   end

   // compare every cycle, away from the active edge
   always @(negedge clk) begin
      if (check_en) begin
         chk("m_out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
         chk("m_in_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
         chk("m_occupancy", {30'b0, occupancy}, mq.size());
         chk("m_out_data", out_data, (mq.size() > 0) ? mq[0] : m_last);
         chk("m_stall_cnt", {28'b0, stall_cnt}, m_stall);
         if (out_valid && out_data == 32'h0000_00C0) seen_c++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 0; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
      seen_c = 0;
      tick();
      tick();
      check_en = 1;
      // reset state
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_in_ready", {31'b0, in_ready}, 1);
      chk("rst_occupancy", {30'b0, occupancy}, 0);
      chk("rst_stall", {28'b0, stall_cnt}, 0);
      chk("rst_out_data", out_data, 0);
      rst = 1;

      // streaming 1..8
      out_ready = 1;
      in_valid = 1;
      for (int i = 1; i <= 8; i++) begin
         in_data = i;
         tick();
         chk("stream_data", out_data, i);
         chk("stream_valid", {31'b0, out_valid}, 1);
         chk("stream_ready", {31'b0, in_ready}, 1);
         chk("stream_stall", {28'b0, stall_cnt}, 0);
      end
      in_valid = 0;
      tick();
      chk("stream_drain", {31'b0, out_valid}, 0);

      // skid fill with A then B
      out_ready = 0; in_valid = 1; in_data = 32'hA;
      tick();
      chk("skid_a_data", out_data, 32'hA);
      chk("skid_a_occ", {30'b0, occupancy}, 1);
      in_data = 32'hB;
      tick();
      chk("skid_b_occ", {30'b0, occupancy}, 2);
      chk("skid_b_ready", {31'b0, in_ready}, 0);
      chk("skid_b_data", out_data, 32'hA);
      in_valid = 0;
      tick();
      chk("skid_hold_occ", {30'b0, occupancy}, 2);
      chk("skid_stall", {28'b0, stall_cnt}, 2);
      out_ready = 1;
      tick();
      chk("skid_pop1_data", out_data, 32'hB);
      chk("skid_pop1_occ", {30'b0, occupancy}, 1);
      tick();
      chk("skid_pop2_occ", {30'b0, occupancy}, 0);

      // flush against an offered payload while FULL
      out_ready = 0; in_valid = 1; in_data = 32'h11;
      tick();
      in_data = 32'h22;
      tick();
      chk("fl_full_occ", {30'b0, occupancy}, 2);
      flush = 1; in_data = 32'hC0;
      tick();
      flush = 0; in_valid = 0;
      chk("fl_valid", {31'b0, out_valid}, 0);
      chk("fl_occ", {30'b0, occupancy}, 0);
      chk("fl_ready", {31'b0, in_ready}, 1);
      chk("fl_main", out_data, 0);
      chk("fl_stall", {28'b0, stall_cnt}, 4);
      out_ready = 1;
      tick();
      tick();
      chk("fl_no_c", seen_c, 0);

      // saturation
      out_ready = 0; in_valid = 1; in_data = 32'h55;
      tick();
      in_valid = 0;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_stall", {28'b0, stall_cnt}, 15);
      flush = 1;
      tick();
      flush = 0;
      chk("sat_after_flush", {28'b0, stall_cnt}, 15);

      // reset while stalled
      rst = 0;
      tick();
      rst = 1;
      chk("rs0_stall", {28'b0, stall_cnt}, 0);
      out_ready = 0; in_valid = 1; in_data = 32'h1;
      tick();
      in_data = 32'h2;
      tick();
      in_valid = 0;
      for (int i = 0; i < 6; i++) tick();
      chk("rs_pre_stall", {28'b0, stall_cnt}, 7);
      chk("rs_pre_occ", {30'b0, occupancy}, 2);
      rst = 0;
      tick();
      rst = 1;
      chk("rs_occ", {30'b0, occupancy}, 0);
      chk("rs_valid", {31'b0, out_valid}, 0);
      chk("rs_ready", {31'b0, in_ready}, 1);
      chk("rs_stall", {28'b0, stall_cnt}, 0);
      in_valid = 1; in_data = 32'h77; out_ready = 1;
      tick();
      in_valid = 0;
      chk("rs_first_data", out_data, 32'h77);
      chk("rs_first_valid", {31'b0, out_valid}, 1);

      // random handshake against the model
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         in_data   = $urandom;
         tick();
      end
      flush = 0; in_valid = 0; out_ready = 1;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
